// File: rtl/bpred_pkg.sv
// Shared constants for the branch predictor: next-PC select encodings,
// 2-bit saturating counter states and the counter step helper.
package bpred_pkg;

  // Next-PC source select encodings
  localparam logic [2:0] PCSEL_SEQ   = 3'd0;  // PC+4
  localparam logic [2:0] PCSEL_PRED  = 3'd1;  // IF predicted branch target
  localparam logic [2:0] PCSEL_BR    = 3'd2;  // EX branch target (mispredicted taken)
  localparam logic [2:0] PCSEL_REG   = 3'd3;  // register target (jr/jalr)
  localparam logic [2:0] PCSEL_JMP   = 3'd4;  // jump target
  localparam logic [2:0] PCSEL_RECOV = 3'd5;  // ex_pc+4 (mispredicted not-taken)

  typedef logic [1:0] bhtCtrT;

  // Counter states; the MSB is the taken prediction
  localparam bhtCtrT CTR_SNT   = 2'd0;
  localparam bhtCtrT CTR_WNT   = 2'd1;
  localparam bhtCtrT CTR_WT    = 2'd2;
  localparam bhtCtrT CTR_ST    = 2'd3;
  localparam bhtCtrT CTR_RESET = CTR_WNT;

  // One saturating step towards taken (up) or not-taken
  function automatic bhtCtrT satStep(input bhtCtrT ctr, input logic up);
    bhtCtrT res;
    res = ctr;
    if (up && ctr != CTR_ST) begin
      res = ctr + 2'd1;
    end else if (!up && ctr != CTR_SNT) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_sat_ctr_array.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters with one
// combinational read port and one clocked update port. Counters live in
// flops so the whole table can be cleared by the asynchronous reset.
module bht_sat_ctr_array
  import bpred_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rdIdx,
  output bhtCtrT           rdCtr,
  input  logic             updEn,
  input  logic [IDX_W-1:0] updIdx,
  input  logic             updTaken
);

  bhtCtrT ctrAll [BHT_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : gEntry
      bhtCtrT ctrReg;

      // Per-entry counter: step on a resolved branch hitting this index
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrReg <= CTR_RESET;
        end else if (updEn && (updIdx == IDX_W'(gi))) begin
          ctrReg <= satStep(ctrReg, updTaken);
        end
      end

      assign ctrAll[gi] = ctrReg;
    end
  endgenerate

  // Read returns the pre-update value; no write-to-read bypass
  assign rdCtr = ctrAll[rdIdx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch/jump resolution and next-PC select with a 2-bit BHT predictor.
// Optional statistics counters are built when BPRED_STATS_EN is defined.
module branch_pred_ctrl
  import bpred_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int PC_W      = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_en,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_is_branch,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jr_jalr,
  input  logic            ex_zero,
  input  logic            ex_pred_taken,
  output logic            if_pred_taken,
  output logic [2:0]      pc_sel,
  output logic            flush
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] ifIdx;
  logic [IDX_W-1:0] exIdx;
  bhtCtrT           ifCtr;
  logic             exTaken;
  logic             exResolve;
  logic             exMispred;

  // Word-aligned PCs: skip the two byte-offset bits
  assign ifIdx = if_pc[IDX_W+1:2];
  assign exIdx = ex_pc[IDX_W+1:2];

  assign exTaken   = ex_branch & ex_zero;
  assign exResolve = ex_valid & ex_branch;
  assign exMispred = exResolve & (exTaken != ex_pred_taken);

  bht_sat_ctr_array #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) uBht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdIdx    (ifIdx),
    .rdCtr    (ifCtr),
    .updEn    (exResolve),
    .updIdx   (exIdx),
    .updTaken (exTaken)
  );

  assign if_pred_taken = pred_en & if_is_branch & ifCtr[1];

  // Next-PC priority: EX redirects override the IF prediction
  always_comb begin
    pc_sel = PCSEL_SEQ;
    if (ex_valid && ex_jr_jalr) begin
      pc_sel = PCSEL_REG;
    end else if (ex_valid && ex_jump) begin
      pc_sel = PCSEL_JMP;
    end else if (exMispred && exTaken) begin
      pc_sel = PCSEL_BR;
    end else if (exMispred) begin
      pc_sel = PCSEL_RECOV;
    end else if (if_pred_taken) begin
      pc_sel = PCSEL_PRED;
    end
  end

  // Any EX redirect kills the younger IF/ID instructions
  always_comb begin
    flush = 1'b0;
    case (pc_sel)
      PCSEL_BR, PCSEL_REG, PCSEL_JMP, PCSEL_RECOV: flush = 1'b1;
      default:                                     flush = 1'b0;
    endcase
  end

`ifdef BPRED_STATS_EN
  logic [31:0] brCntReg;
  logic [31:0] mispredCntReg;

  // Resolved-branch and mispredict counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCntReg      <= '0;
      mispredCntReg <= '0;
    end else begin
      if (exResolve) begin
        brCntReg <= brCntReg + 32'd1;
      end
      if (exMispred) begin
        mispredCntReg <= mispredCntReg + 32'd1;
      end
    end
  end

  assign br_cnt      = brCntReg;
  assign mispred_cnt = mispredCntReg;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl (define BPRED_STATS_EN to
// also exercise the statistics ports).
module tb_branch_pred_ctrl;

  localparam int BHT_DEPTH = 16;
  localparam int PC_W      = 18;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pred_en = 1'b0;
  logic [PC_W-1:0] if_pc = '0;
  logic            if_is_branch = 1'b0;
  logic            ex_valid = 1'b0;
  logic [PC_W-1:0] ex_pc = '0;
  logic            ex_branch = 1'b0;
  logic            ex_jump = 1'b0;
  logic            ex_jr_jalr = 1'b0;
  logic            ex_zero = 1'b0;
  logic            ex_pred_taken = 1'b0;
  logic            if_pred_taken;
  logic [2:0]      pc_sel;
  logic            flush;
`ifdef BPRED_STATS_EN
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: counter values as plain integers, stats as tallies
  int          bhtM [BHT_DEPTH];
  int unsigned brM;
  int unsigned misM;

  always #5 clk = ~clk;

  branch_pred_ctrl #(
    .BHT_DEPTH (BHT_DEPTH),
    .PC_W      (PC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_en       (pred_en),
    .if_pc         (if_pc),
    .if_is_branch  (if_is_branch),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_jr_jalr    (ex_jr_jalr),
    .ex_zero       (ex_zero),
    .ex_pred_taken (ex_pred_taken),
    .if_pred_taken (if_pred_taken),
    .pc_sel        (pc_sel),
    .flush         (flush)
`ifdef BPRED_STATS_EN
    ,
    .br_cnt        (br_cnt),
    .mispred_cnt   (mispred_cnt)
`endif
  );

  function automatic int idxOf(input logic [PC_W-1:0] pc);
    return int'(pc / 4) % BHT_DEPTH;
  endfunction

  function automatic logic mPred();
    return pred_en && if_is_branch && (bhtM[idxOf(if_pc)] >= 2);
  endfunction

  function automatic logic [2:0] mSel();
    logic taken;
    logic mis;
    taken = ex_branch && ex_zero;
    mis   = ex_valid && ex_branch && (taken != ex_pred_taken);
    if (ex_valid && ex_jr_jalr) return 3'd3;
    if (ex_valid && ex_jump)    return 3'd4;
    if (mis && taken)           return 3'd2;
    if (mis)                    return 3'd5;
    if (mPred())                return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic mFlush();
    logic [2:0] s;
    s = mSel();
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4) || (s == 3'd5);
  endfunction

  task automatic resetModel();
    for (int i = 0; i < BHT_DEPTH; i++) bhtM[i] = 1;
    brM  = 0;
    misM = 0;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_branch     = 1'b0;
    ex_jump       = 1'b0;
    ex_jr_jalr    = 1'b0;
    ex_zero       = 1'b0;
    ex_pred_taken = 1'b0;
    if_is_branch  = 1'b0;
  endtask

  // Advance one clock, applying the spec's update rules to the model
  task automatic tick();
    int  i;
    logic taken;
    if (rst_n && ex_valid && ex_branch) begin
      i     = idxOf(ex_pc);
      taken = ex_zero;
      bhtM[i] = taken ? ((bhtM[i] == 3) ? 3 : bhtM[i] + 1)
                      : ((bhtM[i] == 0) ? 0 : bhtM[i] - 1);
      brM++;
      if (taken != ex_pred_taken) misM++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetModel();
    idle();
    rst_n = 1'b0;
    pred_en = 1'b1;
    if_is_branch = 1'b1;
    if_pc = 18'h40;
    #3;
    checks++;
    if (pc_sel !== 3'd0 || flush !== 1'b0 || if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got sel=%0d flush=%0b pred=%0b exp sel=0 flush=0 pred=0",
               pc_sel, flush, if_pred_taken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_sel !== 3'd0 || if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_lookup got sel=%0d pred=%0b exp sel=0 pred=0", pc_sel, if_pred_taken);
    end
`ifdef BPRED_STATS_EN
    checks++;
    if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats got br=%0d mis=%0d exp 0 0", br_cnt, mispred_cnt);
    end
`endif
  endtask

  task automatic test_train_taken();
    idle();
    pred_en = 1'b1;
    if_is_branch = 1'b1;
    if_pc = 18'h40;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
    ex_pc = 18'h40; ex_pred_taken = 1'b0;
    #1;
    checks++;
    if (pc_sel !== 3'd2 || flush !== 1'b1) begin
      failures++;
      $display("FAIL train_first got sel=%0d flush=%0b exp sel=2 flush=1", pc_sel, flush);
    end
    tick();
    checks++;
    if (pc_sel !== 3'd2 || if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL train_second got sel=%0d pred=%0b exp sel=2 pred=1", pc_sel, if_pred_taken);
    end
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1 || pc_sel !== 3'd1 || flush !== 1'b0) begin
      failures++;
      $display("FAIL train_lookup got pred=%0b sel=%0d flush=%0b exp pred=1 sel=1 flush=0",
               if_pred_taken, pc_sel, flush);
    end
  endtask

  task automatic test_recover_saturate();
    idle();
    pred_en = 1'b1; if_is_branch = 1'b1; if_pc = 18'h40;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b0;
    ex_pc = 18'h40; ex_pred_taken = 1'b1;
    #1;
    checks++;
    if (pc_sel !== 3'd5 || flush !== 1'b1) begin
      failures++;
      $display("FAIL recov_sel got sel=%0d flush=%0b exp sel=5 flush=1", pc_sel, flush);
    end
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL recov_weak_t got pred=%0b exp pred=1", if_pred_taken);
    end
    for (int n = 0; n < 4; n++) begin
      ex_valid = 1'b1; ex_pred_taken = 1'b0;
      #1;
      checks++;
      if (pc_sel !== mSel() || flush !== mFlush()) begin
        failures++;
        $display("FAIL recov_nt_%0d got sel=%0d flush=%0b exp sel=%0d flush=%0b",
                 n, pc_sel, flush, mSel(), mFlush());
      end
      tick();
    end
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || pc_sel !== 3'd0) begin
      failures++;
      $display("FAIL recov_sat_zero got pred=%0b sel=%0d exp pred=0 sel=0", if_pred_taken, pc_sel);
    end
    // From 0, one taken step must give 1 (not-taken), a second gives 2 (taken)
    ex_valid = 1'b1; ex_zero = 1'b1; ex_pred_taken = 1'b1;
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL recov_up1 got pred=%0b exp pred=0", if_pred_taken);
    end
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL recov_up2 got pred=%0b exp pred=1", if_pred_taken);
    end
  endtask

  task automatic test_priority();
    idle();
    pred_en = 1'b1; if_is_branch = 1'b1; if_pc = 18'h80;
    ex_valid = 1'b1; ex_pc = 18'h80;
    ex_jr_jalr = 1'b1; ex_jump = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_pred_taken = 1'b0;
    #1;
    checks++;
    if (pc_sel !== 3'd3 || flush !== 1'b1) begin
      failures++;
      $display("FAIL prio_jr got sel=%0d flush=%0b exp sel=3 flush=1", pc_sel, flush);
    end
    tick();
    ex_jr_jalr = 1'b0;
    #1;
    checks++;
    if (pc_sel !== 3'd4 || flush !== 1'b1) begin
      failures++;
      $display("FAIL prio_jump got sel=%0d flush=%0b exp sel=4 flush=1", pc_sel, flush);
    end
    tick();
    // Both branches above trained index 0 to 3; one correct NT step leaves it taken
    ex_jump = 1'b0; ex_zero = 1'b0; ex_pred_taken = 1'b0;
    tick();
    ex_valid = 1'b0; ex_branch = 1'b0;
    ex_jr_jalr = 1'b1; ex_jump = 1'b1;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1 || pc_sel !== 3'd1) begin
      failures++;
      $display("FAIL prio_bht_upd got pred=%0b sel=%0d exp pred=1 sel=1", if_pred_taken, pc_sel);
    end
    idle();
  endtask

  task automatic test_pred_disable();
    idle();
    pred_en = 1'b1; if_is_branch = 1'b1; if_pc = 18'h80;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 18'h80; ex_pred_taken = 1'b1;
    tick();
    ex_valid = 1'b0;
    pred_en = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || pc_sel !== 3'd0) begin
      failures++;
      $display("FAIL dis_lookup got pred=%0b sel=%0d exp pred=0 sel=0", if_pred_taken, pc_sel);
    end
    ex_valid = 1'b1; ex_pred_taken = 1'b0;
    #1;
    checks++;
    if (pc_sel !== 3'd2 || flush !== 1'b1) begin
      failures++;
      $display("FAIL dis_taken got sel=%0d flush=%0b exp sel=2 flush=1", pc_sel, flush);
    end
    tick();
    // Two NT resolves with prediction off still move the counter 3 -> 1
    ex_zero = 1'b0;
    tick();
    tick();
    // Stalled branches must not update
    ex_valid = 1'b0; ex_zero = 1'b1;
    tick();
    tick();
    pred_en = 1'b1;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || pc_sel !== 3'd0) begin
      failures++;
      $display("FAIL dis_update got pred=%0b sel=%0d exp pred=0 sel=0", if_pred_taken, pc_sel);
    end
    idle();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      pred_en       = ($urandom_range(0, 3) != 0);
      if_is_branch  = $urandom_range(0, 1);
      if_pc         = PC_W'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      ex_valid      = ($urandom_range(0, 4) != 0);
      ex_pc         = PC_W'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      ex_branch     = $urandom_range(0, 1);
      ex_jump       = ($urandom_range(0, 9) == 0);
      ex_jr_jalr    = ($urandom_range(0, 9) == 0);
      ex_zero       = $urandom_range(0, 1);
      ex_pred_taken = $urandom_range(0, 1);
      #1;
      checks++;
      if (pc_sel !== mSel() || flush !== mFlush() || if_pred_taken !== mPred()) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_%0d got sel=%0d flush=%0b pred=%0b exp sel=%0d flush=%0b pred=%0b",
                   n, pc_sel, flush, if_pred_taken, mSel(), mFlush(), mPred());
      end
      tick();
    end
`ifdef BPRED_STATS_EN
    checks++;
    if (br_cnt !== brM || mispred_cnt !== misM) begin
      failures++;
      $display("FAIL rand_stats got br=%0d mis=%0d exp br=%0d mis=%0d", br_cnt, mispred_cnt, brM, misM);
    end
`endif
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    pred_en = 1'b1; if_is_branch = 1'b1; if_pc = 18'h40;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 18'h40; ex_pred_taken = 1'b1;
    tick();
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got pred=%0b exp pred=1", if_pred_taken);
    end
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checks++;
    if (if_pred_taken !== 1'b0 || pc_sel !== 3'd0) begin
      failures++;
      $display("FAIL arst_clear got pred=%0b sel=%0d exp pred=0 sel=0", if_pred_taken, pc_sel);
    end
    // Branches presented while in reset must not train the table
    ex_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL arst_post got pred=%0b exp pred=0", if_pred_taken);
    end
    idle();
  endtask

`ifdef BPRED_STATS_EN
  task automatic test_stats();
    logic [1:0] seq [5];
    seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b01; seq[4] = 2'b11;
    idle();
    ex_pc = 18'h100;
    for (int n = 0; n < 5; n++) begin
      ex_valid = 1'b1; ex_branch = 1'b1;
      ex_zero = seq[n][1]; ex_pred_taken = seq[n][0];
      tick();
      // Non-branch traffic in between must not count
      ex_branch = 1'b0; ex_jump = 1'b1;
      tick();
      ex_jump = 1'b0; ex_valid = 1'b0; ex_branch = 1'b1; ex_zero = 1'b1;
      tick();
    end
    checks++;
    if (br_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
      failures++;
      $display("FAIL stats_count got br=%0d mis=%0d exp br=5 mis=2", br_cnt, mispred_cnt);
    end
    ex_valid = 1'b1; ex_zero = 1'b1; ex_pred_taken = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checks++;
    if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stats_arst got br=%0d mis=%0d exp 0 0", br_cnt, mispred_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_train_taken();
    test_recover_saturate();
    test_priority();
    test_pred_disable();
    test_random();
    test_async_reset();
`ifdef BPRED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
